// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: CPU-fed command/data FIFO ahead of the 8-bit SPI output driver.
// Words are 10 bits: [9] power-on request, [8] D/C, [7:0] payload.
// A small sequencer pops one word at a time, strobes spi_start for one
// ce-period while the driver is idle, waits for the driver's busy/done
// handshake (skipped for power-on words) and inserts a one-period gap.
// status = {19'b0, count[7:0], 1'b0, overflow, busy, full, empty}; the
// leading pad is 19 bits so that every named field fits in 32 bits.
module spi_cmd_fifo #(
   parameter int DEPTH        = 16,
   parameter int AW           = 4,
   parameter int BUSY_TIMEOUT = 63
) (
   input  logic        clk_125mhz,
   input  logic        reset,
   input  logic        ce,
   input  logic        wr_en,
   input  logic [9:0]  wr_data,
   input  logic        clr,
   input  logic        spi_idle,
   output logic        spi_start,
   output logic [9:0]  spi_din,
   output logic [31:0] status
);

   localparam int              TW       = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
   localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]     CNT_ZERO = (AW + 1)'(0);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
   localparam logic [AW-1:0]   PTR_ZERO = AW'(0);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [9:0]      mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;
   logic            overflow_r;
   logic [TW-1:0]   timer_r;

   logic            full_s;
   logic            empty_s;
   logic            busy_s;
   logic            pop_s;
   logic            push_s;
   logic            ovf_set_s;
   logic [9:0]      head_s;

   assign full_s  = (count_r == CNT_FULL);
   assign empty_s = (count_r == CNT_ZERO);
   assign busy_s  = (state_r != IDLE);
   assign head_s  = mem_r[rd_ptr_r];

   assign status = {19'd0, 8'(count_r), 1'b0, overflow_r, busy_s, full_s, empty_s};

   // Write-side qualification: clr wins over a store and suppresses overflow.
   always_comb begin
      push_s    = 1'b0;
      ovf_set_s = 1'b0;
      if (clr) begin
         push_s    = 1'b0;
         ovf_set_s = 1'b0;
      end else begin
         push_s    = wr_en & ~full_s;
         ovf_set_s = wr_en & full_s;
      end
   end

   // Sequencer next-state and pop decision.
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s && spi_idle && !clr) begin
               pop_s   = 1'b1;
               state_s = head_s[9] ? GAP : WAIT_BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT_BUSY: begin
            if (!spi_idle) begin
               state_s = WAIT_DONE;
            end else if (timer_r == TMO_LAST) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_BUSY;
            end
         end
         WAIT_DONE: begin
            if (spi_idle) begin
               state_s = GAP;
            end else begin
               state_s = WAIT_DONE;
            end
         end
         GAP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Sequencer state, busy timer and driver-facing output registers.
   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         timer_r   <= {TW{1'b0}};
         spi_start <= 1'b0;
         spi_din   <= 10'd0;
      end else if (ce) begin
         state_r   <= state_s;
         spi_start <= pop_s;
         if (pop_s) begin
            spi_din <= head_s;
         end
         if (state_r == WAIT_BUSY) begin
            timer_r <= timer_r + TMO_ONE;
         end else begin
            timer_r <= {TW{1'b0}};
         end
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         overflow_r <= 1'b0;
      end else if (ce) begin
         if (clr) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + CNT_ONE;
               2'b01:   count_r <= count_r - CNT_ONE;
               default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
               overflow_r <= 1'b1;
            end
         end
      end
   end

   // Storage array; contents are only meaningful between the pointers.
   always_ff @(posedge clk_125mhz) begin
      if (ce && push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: tb/tb_spi_cmd_fifo.sv
// Testbench for spi_cmd_fifo: directed stimulus, expected words queued at
// store time, a forked monitor pops and compares on every spi_start pulse.
module tb_spi_cmd_fifo;

   logic        clk_125mhz = 1'b0;
   logic        reset      = 1'b1;
   logic        ce         = 1'b0;
   logic        wr_en      = 1'b0;
   logic [9:0]  wr_data    = 10'd0;
   logic        clr        = 1'b0;
   logic        man_idle   = 1'b1;
   logic        auto_mode  = 1'b0;
   logic        drv_idle   = 1'b1;
   logic        spi_idle;
   logic        spi_start;
   logic [9:0]  spi_din;
   logic [31:0] status;

   int tests      = 0;
   int fails      = 0;
   int cyc        = 0;
   int n_starts   = 0;
   int last_start = -1;
   int prev_start = -1;
   int drv_busy   = 0;
   int wcyc       = 0;
   logic [9:0] exp_q [$];

   assign spi_idle = auto_mode ? drv_idle : man_idle;

   spi_cmd_fifo #(.DEPTH(16), .AW(4), .BUSY_TIMEOUT(63)) dut (
      .clk_125mhz (clk_125mhz),
      .reset      (reset),
      .ce         (ce),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .clr        (clr),
      .spi_idle   (spi_idle),
      .spi_start  (spi_start),
      .spi_din    (spi_din),
      .status     (status)
   );

   // 125 MHz clock
   always #4 clk_125mhz = ~clk_125mhz;

   // ce: every other clock, changed away from the active edge
   always @(negedge clk_125mhz) ce <= ~ce;

   // ce-edge counter
   always @(posedge clk_125mhz) if (ce) cyc <= cyc + 1;

   function automatic logic [31:0] exp_st(int cnt, bit ovf, bit bsy);
      logic [7:0] c8;
      c8 = cnt[7:0];
      return {19'd0, c8, 1'b0, ovf, bsy, (cnt == 16), (cnt == 0)};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (ce-edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk_125mhz iff ce);
         #2;
      end
   endtask

   task automatic wr(logic [9:0] d, bit expect_issue);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      wcyc    = cyc;
      if (expect_issue) exp_q.push_back(d);
   endtask

   task automatic monitor();
      logic [9:0] e;
      forever begin
         @(posedge clk_125mhz);
         if (ce) begin
            #1;
            if (spi_start) begin
               prev_start = last_start;
               last_start = cyc;
               n_starts++;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_start: got din %h expected no start", spi_din);
               end else begin
                  e = exp_q.pop_front();
                  check("start_data", {22'd0, spi_din}, {22'd0, e});
               end
            end
         end
      end
   endtask

   // Behavioural driver: a data word keeps it busy for 3 ce-periods;
   // power-on words never drop idle.
   task automatic driver();
      forever begin
         @(posedge clk_125mhz);
         if (ce) begin
            #1;
            if (drv_busy > 0) begin
               drv_busy--;
               if (drv_busy == 0) drv_idle = 1'b1;
            end else if (auto_mode && spi_start && !spi_din[9]) begin
               drv_idle = 1'b0;
               drv_busy = 3;
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int guard;
      int n;
      fork
         monitor();
         driver();
      join_none

      // 1: reset state
      tick(3);
      reset = 1'b0;
      tick(2);
      check("reset_status", status, 32'h0000_0001);
      check("reset_start", {31'd0, spi_start}, 32'd0);
      check("reset_din", {22'd0, spi_din}, 32'd0);

      // 2: single data word, latency and long busy hold
      man_idle = 1'b1;
      wr(10'h1AF, 1'b1);
      tick();
      // start set at edge W+1, presented to the driver during period W+2
      check("latency", last_start - wcyc, 32'd1);
      man_idle = 1'b0;
      tick(420);
      check("t2_busy_hold", status, exp_st(0, 1'b0, 1'b1));
      check("t2_one_start", n_starts, 32'd1);
      man_idle = 1'b1;
      tick();
      check("t2_gap_busy", status, exp_st(0, 1'b0, 1'b1));
      tick();
      check("t2_back_idle", status, 32'h0000_0001);

      // 3: fill past full, then drain in order
      man_idle = 1'b0;
      for (int i = 0; i < 17; i++) wr(10'(i), (i < 16));
      check("t3_full_ovf", status, exp_st(16, 1'b1, 1'b0));
      auto_mode = 1'b1;
      guard = 0;
      while (guard < 1000 && !(exp_q.size() == 0 && status == exp_st(0, 1'b1, 1'b0))) begin
         tick();
         guard++;
      end
      check("t3_drained", status, exp_st(0, 1'b1, 1'b0));
      check("t3_starts", n_starts, 32'd17);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t3_clr", status, 32'h0000_0001);

      // 4: power-on word then data word: pops two ce-periods apart
      wr(10'h200, 1'b1);
      wr(10'h0AE, 1'b1);
      n0 = n_starts;
      guard = 0;
      while (guard < 50 && n_starts < 19) begin
         tick();
         guard++;
      end
      check("t4_starts", n_starts, 32'd19);
      check("t4_spacing", last_start - prev_start, 32'd2);
      guard = 0;
      while (guard < 200 && status != 32'h0000_0001) begin
         tick();
         guard++;
      end
      check("t4_settle", status, 32'h0000_0001);

      // 5: simultaneous push/pop, then clr racing a store
      auto_mode = 1'b0;
      man_idle  = 1'b0;
      n0 = n_starts;
      wr(10'h011, 1'b1);
      wr(10'h022, 1'b1);
      wr(10'h033, 1'b1);
      check("t5_count3", status, exp_st(3, 1'b0, 1'b0));
      man_idle = 1'b1;
      wr(10'h044, 1'b1);
      man_idle = 1'b0;
      check("t5_pushpop", status, exp_st(3, 1'b0, 1'b1));
      wr(10'h055, 1'b0);
      wr(10'h066, 1'b0);
      check("t5_count5", status, exp_st(5, 1'b0, 1'b1));
      clr     = 1'b1;
      wr_en   = 1'b1;
      wr_data = 10'h077;
      tick();
      clr   = 1'b0;
      wr_en = 1'b0;
      exp_q.delete();
      check("t5_clr_wr", status, exp_st(0, 1'b0, 1'b1));
      man_idle = 1'b1;
      tick(10);
      check("t5_quiet", status, 32'h0000_0001);
      check("t5_starts", n_starts - n0, 32'd1);

      // 6: busy timeout, then reset during WAIT_DONE
      n0 = n_starts;
      wr(10'h133, 1'b1);
      tick();
      check("t6_start", n_starts - n0, 32'd1);
      n = 0;
      while (status[2] && n < 200) begin
         tick();
         n++;
      end
      check("t6_timeout", n, 32'd63);
      wr(10'h0F0, 1'b1);
      wr(10'h0F1, 1'b0);
      man_idle = 1'b0;
      tick();
      check("t6_wait_done", status, exp_st(1, 1'b0, 1'b1));
      n0 = n_starts;
      #1;
      reset = 1'b1;
      #1;
      check("t6_rst_status", status, 32'h0000_0001);
      check("t6_rst_start", {31'd0, spi_start}, 32'd0);
      check("t6_rst_din", {22'd0, spi_din}, 32'd0);
      exp_q.delete();
      tick(2);
      reset = 1'b0;
      man_idle = 1'b1;
      tick(5);
      check("t6_after_rst", status, 32'h0000_0001);
      check("t6_no_start", n_starts - n0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
